// File: rtl/regfile_banked_if.sv
// Register-file access bundle between the decoder/sequencer (master)
// and the banked register file (slave).
interface regfile_banked_if #(
   parameter int W  = 16,
   parameter int AW = 4,
   parameter int BW = 1
);
   logic [AW-1:0] rsa, rda, wa;
   logic [W-1:0]  rsrc, rdst, wd, isr_vec, pc, sp;
   logic          we, wbyte, inc_src, inc_dst, pc_inc, sp_dec, sr_we;
   logic          int_enter, int_exit;
   logic [3:0]    flags_in, flags;
   logic          gie, bank_ovf, bank_unf;
   logic [BW-1:0] bank;

   modport master (
      output rsa, rda, we, wa, wd, wbyte, inc_src, inc_dst, pc_inc, sp_dec,
             sr_we, flags_in, int_enter, isr_vec, int_exit,
      input  rsrc, rdst, pc, sp, flags, gie, bank, bank_ovf, bank_unf
   );

   modport slave (
      input  rsa, rda, we, wa, wd, wbyte, inc_src, inc_dst, pc_inc, sp_dec,
             sr_we, flags_in, int_enter, isr_vec, int_exit,
      output rsrc, rdst, pc, sp, flags, gie, bank, bank_ovf, bank_unf
   );
endinterface

// File: rtl/regfile_banked.sv
// Banked CPU register file: shared PC/SP/SR/CG2 plus per-bank general
// registers that switch on interrupt entry/exit.
module regfile_banked #(
   parameter int          W       = 16,
   parameter int          NREG    = 16,
   parameter int          NBANK   = 2,
   parameter logic [15:0] SR_MASK = 16'h01FF,
   parameter int          BYPASS  = 1
) (
   input logic             clk,
   input logic             rst,
   regfile_banked_if.slave bus
);
   localparam int AW = $clog2(NREG);
   localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
   localparam logic [W-1:0] SRM = W'(SR_MASK);
   localparam logic [BW-1:0] BANK_TOP = BW'(NBANK - 1);

   logic [W-1:0]  pc_q, sp_q, sr_q;
   logic [W-1:0]  gr [NBANK][NREG];
   logic [W-1:0]  saved_sr [NBANK];
   logic [BW-1:0] bank_q;
   logic          ovf_q, unf_q;

   logic [W-1:0]  wbase, wval, sr_flags;
   logic          upd_en [3];
   logic [AW-1:0] upd_a [3];
   logic [W-1:0]  upd_v [3];

   function automatic logic [W-1:0] rd_raw(input logic [AW-1:0] a);
      if (a == AW'(0))      return pc_q;
      else if (a == AW'(1)) return sp_q;
      else if (a == AW'(2)) return sr_q;
      else if (a == AW'(3)) return '0;
      else                  return gr[bank_q][a];
   endfunction

   function automatic logic [W-1:0] inc_amt(input logic [AW-1:0] a);
      return (!bus.wbyte || a < AW'(2)) ? W'(2) : W'(1);
   endfunction

   always_comb begin
      wbase = bus.wbyte ? {{(W-8){1'b0}}, bus.wd[7:0]} : bus.wd;
      if (bus.wa == AW'(0) || bus.wa == AW'(1)) wval = {wbase[W-1:1], 1'b0};
      else if (bus.wa == AW'(2))                wval = wbase & SRM;
      else                                      wval = wbase;

      sr_flags    = sr_q;
      sr_flags[8] = bus.flags_in[3];
      sr_flags[2] = bus.flags_in[2];
      sr_flags[1] = bus.flags_in[1];
      sr_flags[0] = bus.flags_in[0];
      sr_flags    = sr_flags & SRM;

      // Slots ordered lowest to highest priority; later slots override.
      upd_en[0] = bus.inc_src && bus.rsa != AW'(2) && bus.rsa != AW'(3);
      upd_a[0]  = bus.rsa;
      upd_v[0]  = rd_raw(bus.rsa) + inc_amt(bus.rsa);
      upd_en[1] = bus.inc_dst && bus.rda != AW'(2) && bus.rda != AW'(3);
      upd_a[1]  = bus.rda;
      upd_v[1]  = rd_raw(bus.rda) + inc_amt(bus.rda);
      upd_en[2] = bus.we && bus.wa != AW'(3);
      upd_a[2]  = bus.wa;
      upd_v[2]  = wval;

      bus.rsrc = rd_raw(bus.rsa);
      bus.rdst = rd_raw(bus.rda);
      if (BYPASS != 0 && bus.we && bus.wa != AW'(3)) begin
         if (bus.wa == bus.rsa) bus.rsrc = wval;
         if (bus.wa == bus.rda) bus.rdst = wval;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= '0;
         sp_q   <= '0;
         sr_q   <= '0;
         bank_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
         for (int b = 0; b < NBANK; b++) begin
            saved_sr[b] <= '0;
            for (int r = 0; r < NREG; r++) gr[b][r] <= '0;
         end
      end else begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         if (bus.pc_inc) pc_q <= pc_q + W'(2);
         if (bus.sp_dec) sp_q <= sp_q - W'(2);
         if (bus.sr_we)  sr_q <= sr_flags;
         for (int k = 0; k < 3; k++) begin
            if (upd_en[k]) begin
               if (upd_a[k] == AW'(0))      pc_q <= upd_v[k];
               else if (upd_a[k] == AW'(1)) sp_q <= upd_v[k];
               else if (upd_a[k] == AW'(2)) sr_q <= upd_v[k];
               else                         gr[bank_q][upd_a[k]] <= upd_v[k];
            end
         end
         // Entry saves SR even on overflow so the context stays consistent.
         if (bus.int_enter) begin
            pc_q             <= {bus.isr_vec[W-1:1], 1'b0};
            sr_q             <= '0;
            saved_sr[bank_q] <= sr_q;
            if (bank_q < BANK_TOP) bank_q <= bank_q + 1'b1;
            else                   ovf_q  <= 1'b1;
         end else if (bus.int_exit) begin
            if (bank_q != '0) begin
               bank_q <= bank_q - 1'b1;
               sr_q   <= saved_sr[bank_q - 1'b1];
            end else begin
               unf_q <= 1'b1;
            end
         end
      end
   end

   assign bus.pc       = pc_q;
   assign bus.sp       = sp_q;
   assign bus.flags    = {sr_q[8], sr_q[2], sr_q[1], sr_q[0]};
   assign bus.gie      = sr_q[3];
   assign bus.bank     = bank_q;
   assign bus.bank_ovf = ovf_q;
   assign bus.bank_unf = unf_q;
endmodule

// File: tb/tb_regfile_banked.sv
// Directed self-checking bench for regfile_banked (default parameters).
module tb_regfile_banked;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nchk = 0;
   int   nerr = 0;

   regfile_banked_if #(.W(16), .AW(4), .BW(1)) bus ();

   regfile_banked #(.W(16), .NREG(16), .NBANK(2), .SR_MASK(16'h01FF), .BYPASS(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.rsa = '0; bus.rda = '0; bus.we = 0; bus.wa = '0; bus.wd = '0;
      bus.wbyte = 0; bus.inc_src = 0; bus.inc_dst = 0; bus.pc_inc = 0;
      bus.sp_dec = 0; bus.sr_we = 0; bus.flags_in = '0; bus.int_enter = 0;
      bus.isr_vec = '0; bus.int_exit = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic byt);
      idle();
      bus.we = 1; bus.wa = a; bus.wd = d; bus.wbyte = byt;
      step();
      idle();
   endtask

   initial begin
      idle();
      rst = 1;
      step(); step();
      rst = 0;
      check("rst_pc", bus.pc, 16'h0000);
      check("rst_sp", bus.sp, 16'h0000);
      check("rst_flags", bus.flags, 4'h0);
      check("rst_gie", bus.gie, 1'b0);
      check("rst_bank", bus.bank, 1'b0);

      // bypass and CG2
      bus.we = 1; bus.wa = 5; bus.wd = 16'h1234; bus.rsa = 5; bus.rda = 3;
      #1;
      check("bypass_rsrc", bus.rsrc, 16'h1234);
      check("cg2_rdst", bus.rdst, 16'h0000);
      step(); idle();
      bus.rsa = 5; #1;
      check("r5_stored", bus.rsrc, 16'h1234);
      bus.we = 1; bus.wa = 3; bus.wd = 16'hFFFF; bus.rsa = 3; #1;
      check("cg2_nobypass", bus.rsrc, 16'h0000);
      step(); idle();
      bus.rda = 3; #1;
      check("cg2_after_wr", bus.rdst, 16'h0000);

      // SP/SR write rules
      wr(1, 16'hFFFF, 0);
      wr(2, 16'hFFFF, 1);
      bus.rsa = 2; #1;
      check("sp_even", bus.sp, 16'hFFFE);
      check("sr_byte", bus.rsrc, 16'h00FF);
      check("flags_0111", bus.flags, 4'b0111);
      check("gie_set", bus.gie, 1'b1);

      // flag latch: V=1 N=0 Z=1 C=0 onto SR=00FF
      bus.sr_we = 1; bus.flags_in = 4'b1010;
      step(); idle();
      bus.rsa = 2; #1;
      check("sr_we", bus.rsrc, 16'h01FA);
      check("flags_1010", bus.flags, 4'b1010);

      // we beats sr_we on SR; pc_inc plus sp_dec on other regs
      bus.sr_we = 1; bus.flags_in = 4'b1111; bus.we = 1; bus.wa = 2; bus.wd = 16'h0008;
      bus.pc_inc = 1; bus.sp_dec = 1;
      step(); idle();
      check("we_over_srwe", bus.flags, 4'b0000);
      check("pc_inc", bus.pc, 16'h0002);
      check("sp_dec", bus.sp, 16'hFFFC);

      // autoincrement priority and widths
      wr(6, 16'h0100, 0);
      bus.we = 1; bus.wa = 6; bus.wd = 16'h0010; bus.inc_src = 1; bus.rsa = 6;
      step(); idle();
      bus.rsa = 6; #1;
      check("we_over_inc", bus.rsrc, 16'h0010);
      bus.inc_dst = 1; bus.rda = 6; bus.wbyte = 1;
      step(); idle();
      bus.rsa = 6; #1;
      check("byte_inc_r6", bus.rsrc, 16'h0011);
      wr(0, 16'hFFFE, 0);
      bus.inc_dst = 1; bus.rda = 0; bus.wbyte = 1;
      step(); idle();
      check("pc_wrap", bus.pc, 16'h0000);
      bus.inc_src = 1; bus.rsa = 2;
      step(); idle();
      check("sr_noinc", bus.flags, 4'b0000);

      // interrupt entry/exit with banked R4
      wr(4, 16'hAAAA, 0);
      wr(2, 16'h0009, 0);
      bus.int_enter = 1; bus.isr_vec = 16'hF001;
      step(); idle();
      bus.rsa = 2; bus.rda = 4; #1;
      check("isr_pc", bus.pc, 16'hF000);
      check("isr_sr", bus.rsrc, 16'h0000);
      check("isr_bank", bus.bank, 1'b1);
      check("isr_r4_b1", bus.rdst, 16'h0000);
      wr(4, 16'h5555, 0);
      bus.int_exit = 1;
      step(); idle();
      bus.rsa = 2; bus.rda = 4; #1;
      check("reti_bank", bus.bank, 1'b0);
      check("reti_r4", bus.rdst, 16'hAAAA);
      check("reti_sr", bus.rsrc, 16'h0009);
      check("reti_gie", bus.gie, 1'b1);

      // overflow / underflow
      bus.int_enter = 1; step(); idle();
      check("ent1_ovf", bus.bank_ovf, 1'b0);
      bus.int_enter = 1; step(); idle();
      check("ent2_ovf", bus.bank_ovf, 1'b1);
      check("ent2_bank", bus.bank, 1'b1);
      step();
      check("ovf_1cyc", bus.bank_ovf, 1'b0);
      bus.int_exit = 1; step(); idle();
      check("ex1_bank", bus.bank, 1'b0);
      check("ex1_unf", bus.bank_unf, 1'b0);
      bus.rsa = 2; #1;
      check("ex1_sr", bus.rsrc, 16'h0009);
      bus.int_exit = 1; step(); idle();
      check("ex2_unf", bus.bank_unf, 1'b1);
      step();
      check("unf_1cyc", bus.bank_unf, 1'b0);
      bus.int_exit = 1; step(); idle();
      check("ex3_unf", bus.bank_unf, 1'b1);
      check("ex3_bank", bus.bank, 1'b0);

      // enter+exit together, then reset mid-interrupt
      step();
      bus.int_enter = 1; bus.int_exit = 1; bus.isr_vec = 16'hF001;
      step(); idle();
      check("both_bank", bus.bank, 1'b1);
      check("both_ovf", bus.bank_ovf, 1'b0);
      check("both_unf", bus.bank_unf, 1'b0);
      rst = 1; step(); rst = 0;
      bus.rsa = 5; bus.rda = 4; #1;
      check("rst2_pc", bus.pc, 16'h0000);
      check("rst2_sp", bus.sp, 16'h0000);
      check("rst2_bank", bus.bank, 1'b0);
      check("rst2_flags", bus.flags, 4'h0);
      check("rst2_gie", bus.gie, 1'b0);
      check("rst2_r5", bus.rsrc, 16'h0000);
      check("rst2_r4", bus.rdst, 16'h0000);
      bus.int_exit = 1; step(); idle();
      check("rst2_stack", bus.bank_unf, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/regfile_banked.md
# regfile_banked

Parametrised, multi-bank successor to the CPU register file. It holds PC, SP, SR and the CG2 pseudo-register as shared special-function registers (SFRs), plus general registers replicated across `NBANK` banks for zero-overhead interrupt context switching. It sits between the instruction decoder/sequencer and the ALU. It applies SFR write rules, addressing-mode autoincrement, status-flag latching and an optional write-to-read bypass.

## Interface
Parameters:
- `W`, 16, data width (≥16).
- `NREG`, 16, registers per bank (≥8). `AW = $clog2(NREG)`.
- `NBANK`, 2, general-register banks (≥1). `BW = max(1,$clog2(NBANK))`.
- `SR_MASK`, 16'h01FF, writable SR bits. Other SR bits read 0.
- `BYPASS`, 1, 1 = same-cycle forwarding of `wd` to read ports.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rsa`, `rda`  in  AW  source/destination read addresses.
- `rsrc`, `rdst`  out  W  read data.
- `we`  in  1  writeback enable.
- `wa`  in  AW  writeback address.
- `wd`  in  W  writeback data.
- `wbyte`  in  1  byte operation. Applies to writeback and autoincrement.
- `inc_src`, `inc_dst`  in  1  autoincrement register `rsa` / `rda`.
- `pc_inc`  in  1  PC += 2 (instruction or index fetch).
- `sp_dec`  in  1  SP −= 2.
- `sr_we`  in  1  latch `flags_in` into SR {V,N,Z,C}.
- `flags_in`  in  4  {V,N,Z,C}.
- `int_enter`  in  1  interrupt entry.
- `isr_vec`  in  W  interrupt vector.
- `int_exit`  in  1  RETI completion.
- `pc`, `sp`  out  W  current PC/SP.
- `flags`  out  4  SR {V(8),N(2),Z(1),C(0)}.
- `gie`  out  1  SR bit 3.
- `bank`  out  BW  active bank.
- `bank_ovf`, `bank_unf`  out  1  one-cycle error pulses.

## Operation
Register map:
- R0 = PC, R1 = SP, R2 = SR, R3 = CG2. These four are shared across all banks.
- R4..NREG−1 are banked and indexed by `bank`.
- R3 always reads 0 and ignores all writes and increments.
- Writes to R2 via `rsa`/`rda` autoincrement are ignored.

Write rules:
- Word write (`wbyte`=0):
  - PC/SP get `{wd[W-1:1],0}`.
  - SR gets `wd & SR_MASK`.
  - Others get `wd`.
- Byte write (`wbyte`=1): value is `{0, wd[7:0]}`, then the same PC/SP/SR rules apply.

Autoincrement:
- Amount is +2 if `wbyte`=0 or the target is PC/SP; otherwise +1.
- Arithmetic is modulo 2^W.

Per-register priority when several updates target the same register in one cycle (highest first):
1. `int_enter` (PC, SR only)
2. `we`
3. `inc_dst`
4. `inc_src`
5. `pc_inc` / `sp_dec` / `sr_we`

Lower-priority updates to that register are discarded. Updates to different registers all occur.

`int_enter`:
- PC ← `{isr_vec[W-1:1],0}`.
- `saved_sr[bank]` ← SR.
- SR ← 0.
- If `bank` < NBANK−1: `bank` ← `bank`+1.
- Otherwise the bank is unchanged and `bank_ovf` pulses. SR is still saved into the current slot and cleared.
- Banked contents are not cleared on entry.

`int_exit`:
- If `bank` > 0: `bank` ← `bank`−1 and SR ← `saved_sr[bank−1]`.
- Otherwise `bank_unf` pulses and nothing changes.
- When `int_enter` and `int_exit` are asserted together, `int_enter` wins and `int_exit` is dropped with no pulse.

Bypass (`BYPASS`=1):
- When `we` is asserted and `wa` equals a read address (and is not R3), that read port returns the masked write value combinationally.
- Increments and implicit updates are not forwarded.

## Timing
- Reads are combinational from current state. With `NBANK`=1, read timing matches the previous generation's register file.
- All state updates occur on the rising `clk` edge. Without bypass, new values are visible in the next cycle.
- A bank switch takes effect at the edge. Reads in the `int_enter`/`int_exit` cycle use the old bank, including any `we` to a banked register in that same cycle.
- `bank_ovf`/`bank_unf` are registered and high for exactly one cycle after the offending edge.
- Reset (synchronous, dominates everything):
  - All registers in all banks and all `saved_sr` slots are set to 0.
  - `bank`=0, `bank_ovf`=`bank_unf`=0.
  - Outputs `pc`=`sp`=0, `flags`=0, `gie`=0.
  - Reset mid-interrupt discards the entire bank stack.

## Test plan
- Reset, then `we` R5=16'h1234 with `rsa`=5 and `BYPASS`=1 -> `rsrc`=1234 in the same cycle; `rdst` (rda=3) = 0 always.
- Word write SP=16'hFFFF, then byte write R2=16'hFFFF -> `sp`=FFFE, SR=00FF, `flags`=4'b0111, `gie`=1.
- `inc_src`+`we` on R6 in the same cycle, with `wd`=0010 and R6=0100 -> R6=0010. Next, a byte `inc_dst` on R6 -> 0011; a byte `inc_dst` on PC=FFFE -> 0000 (wrap).
- R4=AAAA in bank 0, SR=0009, `int_enter` with `isr_vec`=F001 -> `pc`=F000, SR=0, `bank`=1, R4 reads bank-1 content. Write R4=5555, `int_exit` -> `bank`=0, R4=AAAA, SR=0009.
- `NBANK`=2: two `int_enter`s -> second gives `bank_ovf` pulse for 1 cycle, `bank` stays 1. Then three `int_exit`s -> the third gives a `bank_unf` pulse.
- `int_enter`+`int_exit` together at `bank`=0 -> `bank`=1 with no error pulse. Assert `rst` during the next cycle -> everything is 0 at the following edge.
